// File: rtl/reaction_session_fsm.sv
// reaction_session_fsm: multi-round reaction timer with random pre-delay, false-start and timeout detection.
// Define REACTION_BEST_EN to track the best time per session; otherwise best_ms is tied to zero.
module reaction_session_fsm #(
   parameter int  TICK_DIV     = 50000,
   parameter int  TIME_W       = 14,
   parameter int  MAX_MS       = 9999,
   parameter int  ROUNDS       = 5,
   parameter int  MIN_DELAY_MS = 1000,
   parameter int  DLY_W        = 11,
   localparam int RW           = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_btn,
   input  logic              react_btn,
   output logic              led,
   output logic [TIME_W-1:0] time_ms,
   output logic              time_valid,
   output logic [TIME_W-1:0] best_ms,
   output logic [RW-1:0]     round_idx,
   output logic              show_error,
   output logic              timeout,
   output logic              session_done
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int CW = $clog2(MIN_DELAY_MS + (1 << DLY_W) + 1);
   localparam logic [TIME_W-1:0] MAX_T      = TIME_W'(MAX_MS);
   localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [RW-1:0]     ROUND_LAST = RW'(ROUNDS - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_TIMING = 3'd2,
      S_RESULT = 3'd3,
      S_ERROR  = 3'd4,
      S_TOUT   = 3'd5,
      S_FINAL  = 3'd6
   } state_t;

   state_t              state_r, next_state_s;
   logic                start_prev_r, react_prev_r;
   logic [15:0]         lfsr_r;
   logic [PW-1:0]       presc_r;
   logic [CW-1:0]       count_r, target_r;
   logic [TIME_W-1:0]   timer_r;
   logic                st_e_s, re_e_s, tick_s;
   logic                new_target_s, new_session_s, next_round_s;
   logic                start_timing_s, capture_s, expire_s;

   assign st_e_s = start_btn & ~start_prev_r;
   assign re_e_s = react_btn & ~react_prev_r;
   assign tick_s = (presc_r == PRESC_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and datapath-control decode; a reaction wins over any same-cycle expiry.
   always_comb begin
      next_state_s   = state_r;
      new_target_s   = 1'b0;
      new_session_s  = 1'b0;
      next_round_s   = 1'b0;
      start_timing_s = 1'b0;
      capture_s      = 1'b0;
      expire_s       = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (st_e_s) begin
               next_state_s  = S_WAIT;
               new_target_s  = 1'b1;
               new_session_s = 1'b1;
            end else begin
               next_state_s = S_IDLE;
            end
         end
         S_WAIT: begin
            if (re_e_s) begin
               next_state_s = S_ERROR;
            end else if (count_r == target_r) begin
               next_state_s   = S_TIMING;
               start_timing_s = 1'b1;
            end else begin
               next_state_s = S_WAIT;
            end
         end
         S_TIMING: begin
            if (re_e_s) begin
               next_state_s = S_RESULT;
               capture_s    = 1'b1;
            end else if (tick_s && (timer_r >= MAX_T - TIME_W'(1))) begin
               next_state_s = S_TOUT;
               expire_s     = 1'b1;
            end else begin
               next_state_s = S_TIMING;
            end
         end
         S_RESULT: begin
            if (st_e_s && (round_idx == ROUND_LAST)) begin
               next_state_s = S_FINAL;
            end else if (st_e_s) begin
               next_state_s = S_WAIT;
               new_target_s = 1'b1;
               next_round_s = 1'b1;
            end else begin
               next_state_s = S_RESULT;
            end
         end
         S_ERROR, S_TOUT: begin
            if (st_e_s) begin
               next_state_s = S_WAIT;
               new_target_s = 1'b1;
            end else begin
               next_state_s = state_r;
            end
         end
         S_FINAL: begin
            if (st_e_s) begin
               next_state_s = S_IDLE;
            end else begin
               next_state_s = S_FINAL;
            end
         end
         default: begin
            next_state_s = S_IDLE;
         end
      endcase
   end

   // Button history (set in reset so held buttons never fire), LFSR and ms prescaler.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_prev_r <= 1'b1;
         react_prev_r <= 1'b1;
         lfsr_r       <= 16'hACE1;
         presc_r      <= {PW{1'b0}};
      end else begin
         start_prev_r <= start_btn;
         react_prev_r <= react_btn;
         lfsr_r       <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
         if (new_target_s || start_timing_s || tick_s) begin
            presc_r <= {PW{1'b0}};
         end else begin
            presc_r <= presc_r + PW'(1);
         end
      end
   end

   // Pre-delay counter, reaction timer, captured result and round index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r    <= {CW{1'b0}};
         target_r   <= {CW{1'b0}};
         timer_r    <= {TIME_W{1'b0}};
         time_ms    <= {TIME_W{1'b0}};
         time_valid <= 1'b0;
         round_idx  <= {RW{1'b0}};
      end else begin
         if (new_target_s) begin
            count_r  <= {CW{1'b0}};
            target_r <= CW'(MIN_DELAY_MS) + CW'(lfsr_r[DLY_W-1:0]);
         end else if ((state_r == S_WAIT) && tick_s && (count_r != target_r)) begin
            count_r <= count_r + CW'(1);
         end
         if (start_timing_s) begin
            timer_r <= {TIME_W{1'b0}};
         end else if ((state_r == S_TIMING) && tick_s && (timer_r != MAX_T)) begin
            timer_r <= timer_r + TIME_W'(1);
         end
         if (new_session_s) begin
            time_ms <= {TIME_W{1'b0}};
         end else if (capture_s) begin
            time_ms <= timer_r;
         end else if (expire_s) begin
            time_ms <= MAX_T;
         end
         time_valid <= capture_s;
         if (new_session_s) begin
            round_idx <= {RW{1'b0}};
         end else if (next_round_s) begin
            round_idx <= round_idx + RW'(1);
         end
      end
   end

   // Moore flags registered from the next state so they track the state register exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led          <= 1'b0;
         show_error   <= 1'b0;
         timeout      <= 1'b0;
         session_done <= 1'b0;
      end else begin
         led          <= (next_state_s == S_TIMING);
         show_error   <= (next_state_s == S_ERROR);
         timeout      <= (next_state_s == S_TOUT);
         session_done <= (next_state_s == S_FINAL);
      end
   end

`ifdef REACTION_BEST_EN
   logic [TIME_W-1:0] best_r;

   // Best time: compared the cycle after a capture, restarted with each session.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best_r <= MAX_T;
      end else if (new_session_s) begin
         best_r <= MAX_T;
      end else if (time_valid && (time_ms < best_r)) begin
         best_r <= time_ms;
      end
   end

   assign best_ms = best_r;
`else
   assign best_ms = {TIME_W{1'b0}};
`endif

endmodule

// File: tb/tb_reaction_session_fsm.sv
// Self-checking bench for reaction_session_fsm: directed vector table, random rounds against a session model.
module tb_reaction_session_fsm;
   localparam int TICK_DIV     = 4;
   localparam int TIME_W       = 14;
   localparam int MAX_MS       = 50;
   localparam int ROUNDS       = 3;
   localparam int MIN_DELAY_MS = 3;
   localparam int DLY_W        = 2;
   localparam int RW           = 2;
   localparam int P_IDLE = 0, P_RES = 1, P_ERR = 2, P_TOUT = 3, P_FIN = 4;
   localparam int K_REACT = 0, K_FALSE = 1, K_TOUT = 2, K_FINAL = 3, K_IDLE = 4;

   typedef struct {
      int kind; int c; int t; int rnd; int best; int err; int tout; int done;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start_btn = 1'b1;
   logic              react_btn = 1'b1;
   logic              led, time_valid, show_error, timeout, session_done;
   logic [TIME_W-1:0] time_ms, best_ms;
   logic [RW-1:0]     round_idx;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] lfsr_m;
   int          m_phase, m_round, m_best, m_time;
   vec_t        vecs[12];

   reaction_session_fsm #(
      .TICK_DIV(TICK_DIV), .TIME_W(TIME_W), .MAX_MS(MAX_MS),
      .ROUNDS(ROUNDS), .MIN_DELAY_MS(MIN_DELAY_MS), .DLY_W(DLY_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_btn(start_btn), .react_btn(react_btn),
      .led(led), .time_ms(time_ms), .time_valid(time_valid), .best_ms(best_ms),
      .round_idx(round_idx), .show_error(show_error), .timeout(timeout),
      .session_done(session_done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      int fb;
      fb = int'((v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 16'd1);
      return (v >> 1) | 16'(fb << 15);
   endfunction

   // Reference copy of the pseudo-random sequence, to know each round's pre-delay.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_m <= 16'hACE1;
      else        lfsr_m <= lfsr_next(lfsr_m);
   end

   function automatic int exp_b(input int v);
`ifdef REACTION_BEST_EN
      return v;
`else
      return 0;
`endif
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic cmp_all(input string tag, input int t, input int rnd, input int b,
                          input int e, input int to, input int d);
      check({tag, ".time_ms"}, time_ms, t);
      check({tag, ".round_idx"}, round_idx, rnd);
      check({tag, ".best_ms"}, best_ms, exp_b(b));
      check({tag, ".show_error"}, show_error, e);
      check({tag, ".timeout"}, timeout, to);
      check({tag, ".session_done"}, session_done, d);
   endtask

   task automatic cmp_model(input string tag);
      cmp_all(tag, m_time, m_round, m_best, int'(m_phase == P_ERR),
              int'(m_phase == P_TOUT), int'(m_phase == P_FIN));
   endtask

   // One round: start, then react c clocks after the LED (K_REACT), react c clocks into
   // the pre-delay (K_FALSE), or never react (K_TOUT). K_FINAL/K_IDLE are bare starts.
   task automatic do_step(input int kind, input int c);
      int  tgt, k, lim;
      bit  seen_led, led_drop, seen_tv;
      if (kind == K_FINAL || kind == K_IDLE) begin
         @(negedge clk); start_btn = 1'b1;
         @(negedge clk); start_btn = 1'b0;
         m_phase = (kind == K_FINAL) ? P_FIN : P_IDLE;
         check("bare_start.led", led, 0);
         return;
      end
      if (m_phase == P_IDLE) begin
         m_round = 0; m_best = MAX_MS; m_time = 0;
      end else if (m_phase == P_RES) begin
         m_round++;
      end
      @(negedge clk);
      tgt = MIN_DELAY_MS + int'(lfsr_m[DLY_W-1:0]);
      start_btn = 1'b1;
      seen_led = 1'b0; k = 0;
      lim = (kind == K_FALSE) ? c : TICK_DIV * (tgt + 2);
      while (k < lim && !seen_led) begin
         @(negedge clk); k++;
         if (k == 1) begin
            start_btn = 1'b0;
            check("wait.round_idx", round_idx, m_round);
            check("wait.flags", int'({show_error, timeout, session_done}), 0);
         end
         seen_led = led;
      end
      if (kind == K_FALSE) begin
         check("false.led_before", led, 0);
         react_btn = 1'b1;
         @(negedge clk); react_btn = 1'b0;
         check("false.show_error", show_error, 1);
         check("false.led_after", led, 0);
         m_phase = P_ERR;
         return;
      end
      check_range("led_delay", k, TICK_DIV * tgt + 1, TICK_DIV * tgt + 3);
      if (kind == K_REACT) begin
         led_drop = 1'b0;
         repeat (c) begin
            @(negedge clk);
            if (!led) led_drop = 1'b1;
         end
         check("react.led_held", int'(led_drop), 0);
         react_btn = 1'b1;
         @(negedge clk); react_btn = 1'b0;
         m_time = c / TICK_DIV;
         if (m_time < m_best) m_best = m_time;
         check("react.time_valid", time_valid, 1);
         check("react.time_ms", time_ms, m_time);
         check("react.led_off", led, 0);
         @(negedge clk);
         check("react.tv_one_cycle", time_valid, 0);
         check("react.best_ms", best_ms, exp_b(m_best));
         m_phase = P_RES;
      end else begin
         k = 0; seen_tv = 1'b0;
         while (k < MAX_MS * TICK_DIV + 10 && !timeout) begin
            @(negedge clk); k++;
            if (time_valid) seen_tv = 1'b1;
         end
         m_time = MAX_MS;
         check_range("tout.delay", k, MAX_MS * TICK_DIV - 1, MAX_MS * TICK_DIV + 1);
         check("tout.time_ms", time_ms, MAX_MS);
         check("tout.no_time_valid", int'(seen_tv), 0);
         check("tout.led_off", led, 0);
         m_phase = P_TOUT;
      end
   endtask

   initial begin
      // c values: 37 ms, a tick-coincident 12 ms, and the last cycle before timeout (49 ms).
      vecs[0]  = '{K_REACT, 148, 37, 0, 37, 0, 0, 0};
      vecs[1]  = '{K_FALSE,   5, 37, 1, 37, 1, 0, 0};
      vecs[2]  = '{K_REACT,  51, 12, 1, 12, 0, 0, 0};
      vecs[3]  = '{K_TOUT,    0, 50, 2, 12, 0, 1, 0};
      vecs[4]  = '{K_REACT, 199, 49, 2, 12, 0, 0, 0};
      vecs[5]  = '{K_FINAL,   0, 49, 2, 12, 0, 0, 1};
      vecs[6]  = '{K_IDLE,    0, 49, 2, 12, 0, 0, 0};
      vecs[7]  = '{K_REACT, 160, 40, 0, 40, 0, 0, 0};
      vecs[8]  = '{K_REACT, 101, 25, 1, 25, 0, 0, 0};
      vecs[9]  = '{K_REACT, 135, 33, 2, 25, 0, 0, 0};
      vecs[10] = '{K_FINAL,   0, 33, 2, 25, 0, 0, 1};
      vecs[11] = '{K_IDLE,    0, 33, 2, 25, 0, 0, 0};

      m_phase = P_IDLE; m_round = 0; m_best = MAX_MS; m_time = 0;
      repeat (3) @(negedge clk);
      cmp_all("reset", 0, 0, MAX_MS, 0, 0, 0);
      check("reset.led", led, 0);
      rst_n = 1'b1;
      begin
         bit flag_seen;
         flag_seen = 1'b0;
         repeat (40) begin
            @(negedge clk);
            if (led || show_error || timeout || session_done || time_valid) flag_seen = 1'b1;
         end
         check("held_buttons.idle", int'(flag_seen), 0);
      end
      start_btn = 1'b0; react_btn = 1'b0;

      for (int i = 0; i < 12; i++) begin
         do_step(vecs[i].kind, vecs[i].c);
         cmp_all($sformatf("vec%0d", i), vecs[i].t, vecs[i].rnd, vecs[i].best,
                 vecs[i].err, vecs[i].tout, vecs[i].done);
      end

      for (int i = 0; i < 30; i++) begin
         int r;
         if (m_phase == P_RES && m_round == ROUNDS - 1) begin
            do_step(K_FINAL, 0);
            cmp_model($sformatf("rand%0d.final", i));
            do_step(K_IDLE, 0);
            cmp_model($sformatf("rand%0d.idle", i));
         end else begin
            r = int'($urandom_range(0, 9));
            if (r < 7)      do_step(K_REACT, int'($urandom_range(0, MAX_MS * TICK_DIV - 1)));
            else if (r < 9) do_step(K_FALSE, int'($urandom_range(1, 10)));
            else            do_step(K_TOUT, 0);
            cmp_model($sformatf("rand%0d", i));
         end
      end

      @(negedge clk); start_btn = 1'b1;
      @(negedge clk); start_btn = 1'b0;
      repeat (30) @(negedge clk);
      rst_n = 1'b0;
      #1;
      cmp_all("midreset", 0, 0, MAX_MS, 0, 0, 0);
      check("midreset.led", led, 0);
      check("midreset.time_valid", time_valid, 0);
      @(negedge clk); rst_n = 1'b1;
      m_phase = P_IDLE;
      do_step(K_REACT, 22);
      cmp_model("after_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
